// File: rtl/aes_pkg.sv
// Shared AES column-mixing definitions: FSM states, the field reduction
// constant, and the row-0 coefficients of the forward and inverse matrices.
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0]  GF_POLY  = 8'h1B;
  localparam logic [31:0] FWD_ROW0 = 32'h02030101;
  localparam logic [31:0] INV_ROW0 = 32'h0E0B0D09;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? GF_POLY : 8'h00);
  endfunction

  // Row r is row 0 rotated right by r, so M[r][k] = row0[(k - r) mod 4].
  function automatic logic [7:0] coef(input logic inv, input logic [1:0] r,
                                      input logic [1:0] k);
    logic [1:0]  j;
    logic [31:0] row;
    logic [7:0]  c;
    j   = k - r;
    row = inv ? INV_ROW0 : FWD_ROW0;
    case (j)
      2'd0:    c = row[31:24];
      2'd1:    c = row[23:16];
      2'd2:    c = row[15:8];
      default: c = row[7:0];
    endcase
    return c;
  endfunction

endpackage

// File: rtl/gf_xtime_mul.sv
// Combinational GF(2^8) byte-by-coefficient multiplier built from an xtime chain;
// each set coefficient bit adds the matching power-of-x multiple of a.
module gf_xtime_mul
  import aes_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] c,
  output logic [7:0] p
);

  logic [7:0] pow [0:7];

  assign pow[0] = a;

  generate
    for (genvar gi = 1; gi < 8; gi++) begin : g_chain
      assign pow[gi] = xtime(pow[gi-1]);
    end
  endgenerate

  always_comb begin
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (c[i]) p = p ^ pow[i];
    end
  end

endmodule

// File: rtl/mix_col_seq.sv
// Sequential (Inv)MixColumns on one 32-bit column: one GF(2^8) term per cycle,
// 16 cycles per column, with valid/ready handshakes on both sides.
module mix_col_seq
  import aes_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_col,
  input  logic        in_inv,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_col,
  output logic        busy
);

  state_t      state_reg;
  logic        in_ready_reg;
  logic        out_valid_reg;
  logic [31:0] out_col_reg;
  logic [31:0] col_reg;
  logic        inv_reg;
  logic [31:0] acc_reg;
  logic [31:0] acc_next;
  logic [3:0]  idx_reg;

  logic [1:0]  row_sel;
  logic [1:0]  col_sel;
  logic [7:0]  a_byte;
  logic [7:0]  coef_byte;
  logic [7:0]  term;

  assign row_sel = idx_reg[3:2];
  assign col_sel = idx_reg[1:0];

  always_comb begin
    case (col_sel)
      2'd0:    a_byte = col_reg[31:24];
      2'd1:    a_byte = col_reg[23:16];
      2'd2:    a_byte = col_reg[15:8];
      default: a_byte = col_reg[7:0];
    endcase
  end

  assign coef_byte = coef(inv_reg, row_sel, col_sel);

  gf_xtime_mul u_mul (
    .a (a_byte),
    .c (coef_byte),
    .p (term)
  );

  // Only the byte of the row currently being accumulated picks up the term.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_acc
      assign acc_next[31-8*gi -: 8] = acc_reg[31-8*gi -: 8] ^
                                      ((row_sel == 2'(gi)) ? term : 8'h00);
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      in_ready_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
      out_col_reg   <= 32'h0;
      col_reg       <= 32'h0;
      inv_reg       <= 1'b0;
      acc_reg       <= 32'h0;
      idx_reg       <= 4'h0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_ready_reg && in_valid) begin
            col_reg      <= in_col;
            inv_reg      <= in_inv;
            acc_reg      <= 32'h0;
            idx_reg      <= 4'h0;
            in_ready_reg <= 1'b0;
            state_reg    <= RUN;
          end else begin
            in_ready_reg <= 1'b1;
          end
        end
        RUN: begin
          acc_reg <= acc_next;
          idx_reg <= idx_reg + 4'd1;
          if (idx_reg == 4'd15) begin
            out_col_reg   <= acc_next;
            out_valid_reg <= 1'b1;
            state_reg     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            state_reg     <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign out_col   = out_col_reg;
  assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_mix_col_seq.sv
// Directed self-checking bench for mix_col_seq: AES column vectors, latency,
// backpressure, mid-run reset and back-to-back throughput.
module tb_mix_col_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_col = 32'h0;
  logic        in_inv = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_col;
  logic        busy;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mix_col_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_col    (in_col),
    .in_inv    (in_inv),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_col   (out_col),
    .busy      (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s_ready_timeout in_ready=%b required=1", name, in_ready);
    end
  endtask

  // Accept one column, measure latency, check result, then release it.
  task automatic run_col(input logic [31:0] col, input logic inv,
                         input logic [31:0] exp, input string name);
    int lat;
    wait_ready(name);
    in_valid = 1'b1; in_col = col; in_inv = inv;
    tick();
    in_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL %s_accept busy=%b in_ready=%b required busy=1 in_ready=0", name, busy, in_ready);
    end
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    checks++;
    if (lat !== 16) begin
      failures++;
      $display("FAIL %s_latency got=%0d required=16", name, lat);
    end
    checks++;
    if (out_col !== exp) begin
      failures++;
      $display("FAIL %s_result got=%h required=%h", name, out_col, exp);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_col !== exp) begin
      failures++;
      $display("FAIL %s_release out_valid=%b busy=%b out_col=%h required 0 0 %h", name, out_valid, busy, out_col, exp);
    end
    $display("col %s in=%h inv=%b out=%h latency=%0d", name, col, inv, out_col, lat);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || out_col !== 32'h0) begin
      failures++;
      $display("FAIL reset_state in_ready=%b out_valid=%b busy=%b out_col=%h required 0 0 0 0", in_ready, out_valid, busy, out_col);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_first_edge in_ready=%b required=1", in_ready);
    end
    $display("reset in_ready=%b out_valid=%b busy=%b out_col=%h", in_ready, out_valid, busy, out_col);
  endtask

  task automatic test_forward();
    run_col(32'hdb135345, 1'b0, 32'h8e4da1bc, "fwd_fips");
    run_col(32'hd4bf5d30, 1'b0, 32'h046681e5, "fwd_d4bf");
    run_col(32'hc6c6c6c6, 1'b0, 32'hc6c6c6c6, "fwd_c6");
  endtask

  task automatic test_inverse();
    run_col(32'h8e4da1bc, 1'b1, 32'hdb135345, "inv_8e4d");
    run_col(32'h046681e5, 1'b1, 32'hd4bf5d30, "inv_0466");
  endtask

  task automatic test_backpressure();
    int lat;
    int bad;
    wait_ready("bp");
    in_valid = 1'b1; in_col = 32'hdb135345; in_inv = 1'b0;
    tick();
    in_valid = 1'b0;
    out_ready = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    // A new offer and a differently-shaped one while DONE must be ignored.
    in_valid = 1'b1; in_col = 32'h12345678; in_inv = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (out_col !== 32'h8e4da1bc || in_ready !== 1'b0 || out_valid !== 1'b1) begin
        failures++;
        bad++;
        $display("FAIL bp_hold cyc=%0d out_col=%h in_ready=%b out_valid=%b required 8e4da1bc 0 1", i, out_col, in_ready, out_valid);
      end
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (busy !== 1'b0 || out_valid !== 1'b0 || out_col !== 32'h8e4da1bc) begin
        failures++;
        $display("FAIL bp_no_extra cyc=%0d busy=%b out_valid=%b out_col=%h required 0 0 8e4da1bc", i, busy, out_valid, out_col);
      end
    end
    $display("backpressure out=%h hold_errors=%0d", out_col, bad);
  endtask

  task automatic test_reset_mid_run();
    wait_ready("rst_run");
    in_valid = 1'b1; in_col = 32'hd4bf5d30; in_inv = 1'b0;
    tick();
    in_valid = 1'b0;
    repeat (7) tick();
    rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || out_col !== 32'h0) begin
      failures++;
      $display("FAIL rst_run_async in_ready=%b out_valid=%b busy=%b out_col=%h required 0 0 0 0", in_ready, out_valid, busy, out_col);
    end
    @(negedge clk);
    rst = 1'b0;
    $display("reset_mid_run in_ready=%b out_valid=%b busy=%b out_col=%h", in_ready, out_valid, busy, out_col);
    run_col(32'hf20a225c, 1'b0, 32'h9fdc589d, "after_rst");
  endtask

  task automatic test_back_to_back();
    logic [31:0] cols [0:2];
    logic [31:0] exps [0:2];
    int ptr;
    int nres;
    int last;
    logic acc;
    cols[0] = 32'hdb135345; exps[0] = 32'h8e4da1bc;
    cols[1] = 32'hd4bf5d30; exps[1] = 32'h046681e5;
    cols[2] = 32'hf20a225c; exps[2] = 32'h9fdc589d;
    ptr = 0; nres = 0; last = -1;
    wait_ready("b2b");
    in_valid = 1'b1; in_inv = 1'b0; in_col = cols[0];
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 80; cyc++) begin
      acc = in_ready & in_valid;
      tick();
      if (acc) begin
        ptr++;
        if (ptr < 3) in_col = cols[ptr];
        else in_valid = 1'b0;
      end
      if (out_valid === 1'b1) begin
        checks++;
        if (nres > 2 || out_col !== exps[nres > 2 ? 2 : nres]) begin
          failures++;
          $display("FAIL b2b_result n=%0d got=%h required=%h", nres, out_col, exps[nres > 2 ? 2 : nres]);
        end
        if (last >= 0) begin
          checks++;
          if (cyc - last !== 18) begin
            failures++;
            $display("FAIL b2b_period n=%0d got=%0d required=18", nres, cyc - last);
          end
        end
        $display("b2b result n=%0d out=%h cycle=%0d", nres, out_col, cyc);
        last = cyc;
        nres++;
      end
    end
    out_ready = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (nres !== 3) begin
      failures++;
      $display("FAIL b2b_count got=%0d required=3", nres);
    end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_inverse();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mix_col_seq.md
MIX_COL_SEQ -- requirements
Module: mix_col_seq

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; the ports SHALL be named clk and rst.
REQ-002 The ports SHALL be, one per line (name, direction, width, meaning):
 clk  in  1  rising-edge clock
 rst  in  1  async active-high reset
 in_valid  in  1  column offered
 in_ready  out  1  block can accept a column
 in_col  in  32  column; [31:24]=row0 a0, [23:16]=a1, [15:8]=a2, [7:0]=a3
 in_inv  in  1  0 = MixColumns, 1 = InvMixColumns
 out_valid  out  1  result column available
 out_ready  in  1  consumer accepts result
 out_col  out  32  result column, same byte order as in_col
 busy  out  1  high in RUN or DONE
REQ-003 The block SHALL have no parameters.

Function
REQ-004 The FSM SHALL have states IDLE, RUN and DONE.
REQ-005 in_ready SHALL equal 1 only in IDLE, and 0 in RUN, in DONE and during reset.
REQ-006 In IDLE, a rising edge with in_valid=1 SHALL latch in_col and in_inv, clear the accumulator, clear the 4-bit term counter and enter RUN.
REQ-007 Each RUN cycle SHALL accumulate exactly one term: acc[r] <= acc[r] XOR (M[r][k] * a_k), where r = idx[3:2] and k = idx[1:0].
REQ-008 Multiplication SHALL be in GF(2^8) modulo x^8+x^4+x^3+x+1 (reduction 8'h1B); addition SHALL be bytewise XOR.
REQ-009 M SHALL be circulant: forward row0 = {02,03,01,01}; inverse row0 = {0E,0B,0D,09}; row r is row0 rotated right by r.
REQ-010 RUN SHALL last exactly 16 cycles (idx 0..15); at idx=15 the FSM SHALL load out_col from the final accumulator and enter DONE.
REQ-011 out_valid SHALL first be observed high after the 16th rising edge following the accepting edge.
REQ-012 In DONE, out_valid SHALL be 1 and out_col SHALL be held stable until an edge with out_ready=1. On that edge the FSM SHALL return to IDLE and out_valid SHALL fall.
REQ-013 out_col SHALL keep its last value in IDLE and RUN; only entry to DONE SHALL change it.
REQ-014 Changes on in_valid, in_col or in_inv during RUN or DONE SHALL be ignored.
REQ-015 out_ready asserted outside DONE SHALL have no effect.
REQ-016 The accepting and releasing handshakes SHALL NOT overlap; the minimum period between accepted columns SHALL be 18 cycles.
REQ-017 The term counter SHALL NOT wrap outside RUN; it SHALL wrap from 15 to 0 only on the RUN-to-DONE transition.

Reset
REQ-018 While rst=1 the block SHALL hold: state=IDLE, in_ready=0, out_valid=0, busy=0, out_col=32'h0, accumulator=0, counter=0, latched inputs=0.
REQ-019 Assertion of rst mid-RUN or mid-DONE SHALL abort the operation immediately, with no output handshake.
REQ-020 On the first edge after rst deasserts, in_ready SHALL be 1.

Structure
REQ-021 A shared package aes_pkg SHALL hold the FSM state enum, the reduction constant 8'h1B, and the forward and inverse row0 coefficient constants.
REQ-022 A combinational sub-module gf_xtime_mul SHALL multiply a byte by a coefficient in {01,02,03,09,0B,0D,0E} using xtime chains.
REQ-023 The accumulator, counter, FSM and handshake logic SHALL reside in mix_col_seq.

Verification
REQ-024 Forward FIPS vector: in_col=32'hdb135345, in_inv=0 -> out_col=32'h8e4da1bc with 16-cycle latency.
REQ-025 Forward vectors: in_col=32'hd4bf5d30 -> 32'h046681e5; in_col=32'hc6c6c6c6 -> 32'hc6c6c6c6.
REQ-026 Inverse: in_col=32'h8e4da1bc, in_inv=1 -> 32'hdb135345; in_col=32'h046681e5 -> 32'hd4bf5d30.
REQ-027 Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_col stable and in_ready=0 throughout; a new in_valid pulse during this time is ignored.
REQ-028 Reset at RUN idx=7 -> all outputs reach reset values asynchronously; a following column 32'hf20a225c -> 32'h9fdc589d.
REQ-029 Back-to-back columns with in_valid and out_ready held at 1 -> one result every 18 cycles, no dropped or duplicated results.
